// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number pool scheduler.
// Holds the FSM state enum, the LFSR tap mask, the warm-up length and the default seed.
// Also provides the LFSR step and nibble helper functions used by the LFSR core.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESEED = 2'd1,
        WARMUP = 2'd2
    } rng_state_t;

    // Taps at bits 15, 4, 2 and 1; XOR of the masked state is the feedback bit
    localparam logic [15:0] LFSR_TAPS    = 16'h8016;
    localparam int          WARMUP_LEN   = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] d);
        return {d[14:0], ^(d & LFSR_TAPS)};
    endfunction

    // Scattered bit pick so adjacent nibbles share fewer shifted bits
    function automatic logic [3:0] lfsr_nibble(input logic [15:0] d);
        return {d[0], d[15], d[2], d[13]};
    endfunction

endpackage

// File: rtl/rng_lfsr16_core.sv
// 16-bit Fibonacci LFSR holding the shared random state, with load and step controls.
// Latency: load/step take effect at the next clock edge; nibble output is combinational from the current state.
// Backpressure: none; the state holds whenever neither load nor step is asserted (load wins over step).
module rng_lfsr16_core
    import rng_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_step,
    output logic [3:0]  o_nibble
);

    logic [15:0] r_d;

    // State register: reset to the seed, otherwise load, step or hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d <= SEED;
        end else if (i_load) begin
            r_d <= i_load_val;
        end else if (i_step) begin
            r_d <= lfsr_step(r_d);
        end
    end

    assign o_nibble = lfsr_nibble(r_d);

endmodule

// File: rtl/rng_pool_scheduler.sv
// Round-robin scheduler sharing one LFSR among N_REQ requesters, one 4-bit nibble per grant, plus reseed sequencing.
// Latency: 1 cycle from REQ sample to registered GNT/RND/VALID; reseed ack 1 cycle after the request is seen.
// Backpressure: no grants while BUSY (reseed, and 16-cycle warm-up when RNG_WARMUP_EN is defined); ungranted REQ is not stored.
module rng_pool_scheduler
    import rng_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [15:0] SEED_DEFAULT = DEFAULT_SEED
) (
    input  logic             i_trig,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [3:0]       o_rnd,
    output logic             o_valid,
    input  logic             i_reseed_req,
    input  logic [15:0]      i_reseed_val,
    output logic             o_reseed_ack,
    output logic             o_busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    rng_state_t        r_state;
    logic [PW-1:0]     r_ptr;
    logic [N_REQ-1:0]  r_gnt;
    logic [3:0]        r_rnd;
    logic              r_valid;
    logic              r_ack;
    logic              r_busy;
`ifdef RNG_WARMUP_EN
    logic [3:0]        r_wcnt;
`endif

    logic [N_REQ-1:0]  w_rot;
    logic              w_win_vld;
    logic [PW:0]       w_win_sum;
    logic [PW-1:0]     w_win_idx;
    logic [PW-1:0]     w_ptr_nxt;
    logic [3:0]        w_nibble;
    logic              w_grant;
    logic              w_load;
    logic              w_step;
    logic [15:0]       w_seed;

    // Round-robin search: rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        w_rot     = N_REQ'({i_req, i_req} >> r_ptr);
        w_win_vld = 1'b0;
        w_win_sum = {1'b0, r_ptr};
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_win_vld && w_rot[i]) begin
                w_win_vld = 1'b1;
                w_win_sum = {1'b0, r_ptr} + (PW+1)'(i);
            end
        end
        if (w_win_sum >= (PW+1)'(N_REQ)) begin
            w_win_sum = w_win_sum - (PW+1)'(N_REQ);
        end
        w_win_idx = w_win_sum[PW-1:0];
        w_ptr_nxt = (w_win_sum == (PW+1)'(N_REQ-1)) ? '0 : (w_win_sum[PW-1:0] + 1'b1);
    end

    assign w_grant = (r_state == IDLE) && !i_reseed_req && w_win_vld;
    assign w_load  = (r_state == RESEED);
    assign w_seed  = (i_reseed_val == 16'h0000) ? SEED_DEFAULT : i_reseed_val;
`ifdef RNG_WARMUP_EN
    assign w_step  = w_grant || (r_state == WARMUP);
`else
    assign w_step  = w_grant;
`endif

    rng_lfsr16_core #(
        .SEED       (SEED_DEFAULT)
    ) u_lfsr (
        .i_clk      (i_trig),
        .i_rst      (i_reset),
        .i_load     (w_load),
        .i_load_val (w_seed),
        .i_step     (w_step),
        .o_nibble   (w_nibble)
    );

    // Control FSM with registered grant, nibble, ack and busy outputs
    always_ff @(posedge i_trig) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_rnd   <= 4'h0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef RNG_WARMUP_EN
            r_wcnt  <= 4'd0;
`endif
        end else begin
            r_gnt   <= '0;
            r_rnd   <= 4'h0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_reseed_req) begin
                        r_state <= RESEED;
                    end else if (w_win_vld) begin
                        r_gnt   <= N_REQ'(1) << w_win_idx;
                        r_rnd   <= w_nibble;
                        r_valid <= 1'b1;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                RESEED: begin
                    r_ack  <= 1'b1;
                    r_busy <= 1'b1;
`ifdef RNG_WARMUP_EN
                    r_state <= WARMUP;
                    r_wcnt  <= 4'd0;
`else
                    r_state <= IDLE;
`endif
                end
`ifdef RNG_WARMUP_EN
                WARMUP: begin
                    r_busy <= 1'b1;
                    if (r_wcnt == 4'(WARMUP_LEN-1)) begin
                        r_state <= IDLE;
                        r_wcnt  <= 4'd0;
                    end else begin
                        r_wcnt  <= r_wcnt + 4'd1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rnd        = r_rnd;
    assign o_valid      = r_valid;
    assign o_reseed_ack = r_ack;
    assign o_busy       = r_busy;

endmodule
